// File: rtl/gh_uart_rx_sampler_if.sv
// Signal bundle between the UART receive sampler and its environment:
// the baud enable, the serial line, the per-character configuration, the shift-register controls and the status flags.
`timescale 1ns/1ps
interface gh_uart_rx_sampler_if;
    logic       brc;
    logic       rx;
    logic [3:0] num_bits;
    logic       parity_en;
    logic       parity_even;
    logic       two_stop;
    logic       sr_clr;
    logic       sr_se;
    logic       sr_d;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       break_err;
    logic       busy;

    modport master (
        output brc, rx, num_bits, parity_en, parity_even, two_stop,
        input  sr_clr, sr_se, sr_d, rx_done, parity_err, frame_err, break_err, busy
    );

    modport slave (
        input  brc, rx, num_bits, parity_en, parity_even, two_stop,
        output sr_clr, sr_se, sr_d, rx_done, parity_err, frame_err, break_err, busy
    );
endinterface

// File: rtl/gh_uart_rx_sampler.sv
// UART receive bit sampler: finds the start bit, samples each bit at mid-cell on the 16x enable
// and drives a downstream shift register so the word lands right-aligned.
// state     | meaning
// IDLE      | line idle, waiting for a low tick
// START     | checking the start bit at mid-cell
// DATA      | sampling data bits, shifting each into the register
// PAD       | shifting zeros above a short word
// PARITY    | sampling the parity bit
// STOP1     | sampling the first stop bit
// STOP2     | sampling the second stop bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
`timescale 1ns/1ps
module gh_uart_rx_sampler #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 srst,
    gh_uart_rx_sampler_if.slave bus
);
    localparam logic [4:0] WIDTH5 = 5'(WIDTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAD, PARITY, STOP1, STOP2, WAIT_HIGH
    } state_t;

    state_t     state, state_nx;
    logic [3:0] tick_cnt, tick_nx;
    logic [4:0] bit_cnt, bit_nx;
    logic [4:0] nb_q, nb_nx, nb_clamp;
    logic       pen_q, pen_nx, pev_q, pev_nx, two_q, two_nx;
    logic       par_acc, par_nx, any_one, one_nx, fe_acc, fe_nx, pb_acc, pb_nx;
    logic       clr_q, clr_nx, se_q, se_nx, d_q, d_nx, done_q, done_nx;
    logic       perr_q, perr_nx, ferr_q, ferr_nx, berr_q, berr_nx, busy_q;
    logic       sample, finish;

    assign sample = bus.brc && (tick_cnt == 4'd7);

    always_comb begin
        if (bus.num_bits < 4'd5)
            nb_clamp = 5'd5;
        else if ({1'b0, bus.num_bits} > WIDTH5)
            nb_clamp = WIDTH5;
        else
            nb_clamp = {1'b0, bus.num_bits};
    end

    always_comb begin
        state_nx = state;
        tick_nx  = bus.brc ? tick_cnt + 4'd1 : tick_cnt;
        bit_nx   = bit_cnt;
        nb_nx    = nb_q;
        pen_nx   = pen_q;
        pev_nx   = pev_q;
        two_nx   = two_q;
        par_nx   = par_acc;
        one_nx   = any_one;
        fe_nx    = fe_acc;
        pb_nx    = pb_acc;
        clr_nx   = 1'b0;
        se_nx    = 1'b0;
        d_nx     = 1'b0;
        done_nx  = 1'b0;
        perr_nx  = perr_q;
        ferr_nx  = ferr_q;
        berr_nx  = berr_q;
        finish   = 1'b0;

        unique case (state)
            IDLE: if (bus.brc && !bus.rx) begin
                tick_nx  = 4'd0;
                state_nx = START;
            end
            START: if (sample) begin
                if (bus.rx) begin
                    state_nx = IDLE;
                end else begin
                    clr_nx   = 1'b1;
                    par_nx   = 1'b0;
                    one_nx   = 1'b0;
                    fe_nx    = 1'b0;
                    pb_nx    = 1'b0;
                    nb_nx    = nb_clamp;
                    pen_nx   = bus.parity_en;
                    pev_nx   = bus.parity_even;
                    two_nx   = bus.two_stop;
                    bit_nx   = nb_clamp;
                    state_nx = DATA;
                end
            end
            DATA: if (sample) begin
                se_nx  = 1'b1;
                d_nx   = bus.rx;
                par_nx = par_acc ^ bus.rx;
                one_nx = any_one | bus.rx;
                if (bit_cnt == 5'd1) begin
                    bit_nx = WIDTH5 - nb_q;
                    if (nb_q == WIDTH5)
                        state_nx = pen_q ? PARITY : STOP1;
                    else
                        state_nx = PAD;
                end else begin
                    bit_nx = bit_cnt - 5'd1;
                end
            end
            // Padding ticks fall between sample points, so the bit timing is untouched.
            PAD: if (bus.brc) begin
                se_nx  = 1'b1;
                bit_nx = bit_cnt - 5'd1;
                if (bit_cnt == 5'd1)
                    state_nx = pen_q ? PARITY : STOP1;
            end
            PARITY: if (sample) begin
                pb_nx    = (par_acc ^ bus.rx) != ~pev_q;
                one_nx   = any_one | bus.rx;
                state_nx = STOP1;
            end
            STOP1: if (sample) begin
                one_nx = any_one | bus.rx;
                if (!bus.rx) fe_nx = 1'b1;
                if (two_q) state_nx = STOP2;
                else       finish   = 1'b1;
            end
            STOP2: if (sample) begin
                one_nx = any_one | bus.rx;
                if (!bus.rx) fe_nx = 1'b1;
                finish = 1'b1;
            end
            WAIT_HIGH: if (bus.brc && bus.rx) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (finish) begin
            done_nx  = 1'b1;
            perr_nx  = pb_nx;
            ferr_nx  = fe_nx;
            berr_nx  = !one_nx;
            state_nx = fe_nx ? WAIT_HIGH : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 5'd0;
            nb_q     <= 5'd5;
            pen_q    <= 1'b0;
            pev_q    <= 1'b0;
            two_q    <= 1'b0;
            par_acc  <= 1'b0;
            any_one  <= 1'b0;
            fe_acc   <= 1'b0;
            pb_acc   <= 1'b0;
            clr_q    <= 1'b0;
            se_q     <= 1'b0;
            d_q      <= 1'b0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            berr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_cnt  <= bit_nx;
            nb_q     <= nb_nx;
            pen_q    <= pen_nx;
            pev_q    <= pev_nx;
            two_q    <= two_nx;
            par_acc  <= par_nx;
            any_one  <= one_nx;
            fe_acc   <= fe_nx;
            pb_acc   <= pb_nx;
            clr_q    <= clr_nx;
            se_q     <= se_nx;
            d_q      <= d_nx;
            done_q   <= done_nx;
            perr_q   <= perr_nx;
            ferr_q   <= ferr_nx;
            berr_q   <= berr_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    assign bus.sr_clr     = clr_q;
    assign bus.sr_se      = se_q;
    assign bus.sr_d       = d_q;
    assign bus.rx_done    = done_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.break_err  = berr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_gh_uart_rx_sampler.sv
// Directed bench for the UART receive sampler: drives frames tick by tick and models the downstream shift register.
`timescale 1ns/1ps
module tb_gh_uart_rx_sampler;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic srst;
    int   n_chk = 0;
    int   n_bad = 0;
    int   clr_cnt = 0;
    int   se_cnt = 0;
    int   done_cnt = 0;
    int   overlap_cnt = 0;
    logic [WIDTH-1:0] sr_q = '0;

    gh_uart_rx_sampler_if u_if();

    gh_uart_rx_sampler #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    // Downstream shift register model plus pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (int'(u_if.sr_clr) + int'(u_if.sr_se) + int'(u_if.rx_done) > 1) overlap_cnt++;
        if (u_if.sr_clr) begin
            clr_cnt++;
            sr_q = '0;
        end
        if (u_if.sr_se) begin
            se_cnt++;
            sr_q = {u_if.sr_d, sr_q[WIDTH-1:1]};
        end
        if (u_if.rx_done) done_cnt++;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({u_if.sr_clr, u_if.sr_se, u_if.sr_d, u_if.rx_done,
                     u_if.parity_err, u_if.frame_err, u_if.break_err, u_if.busy});
    endfunction

    task automatic tick(input logic r);
        u_if.rx  = r;
        u_if.brc = 1'b1;
        @(posedge clk); #1;
        u_if.brc = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b);
        repeat (16) tick(b);
    endtask

    task automatic send_frame(input logic [15:0] data, input int nb, input logic pen, input logic pbit,
                              input logic s1, input logic s2en, input logic s2);
        logic [15:0] d;
        d = data;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (s2en) send_bit(s2);
    endtask

    task automatic config_set(input logic [3:0] nb, input logic pen, input logic pev, input logic two);
        u_if.num_bits    = nb;
        u_if.parity_en   = pen;
        u_if.parity_even = pev;
        u_if.two_stop    = two;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, s0, d0;
        srst     = 1'b1;
        u_if.brc = 1'b0;
        u_if.rx  = 1'b1;
        config_set(4'd8, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", outs(), 0);
        srst = 1'b0;
        repeat (4) tick(1'b1);

        // 8N1 0xA5
        c0 = clr_cnt; s0 = se_cnt; d0 = done_cnt;
        send_frame(16'h00A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) tick(1'b1);
        check_val("a5_clr", clr_cnt - c0, 1);
        check_val("a5_shifts", se_cnt - s0, 8);
        check_val("a5_done", done_cnt - d0, 1);
        check_val("a5_data", int'(sr_q), 'hA5);
        check_val("a5_flags", int'({u_if.parity_err, u_if.frame_err, u_if.break_err}), 0);
        check_val("a5_busy", int'(u_if.busy), 0);

        // 5 bits 0x13, even parity, correct parity bit 1
        config_set(4'd5, 1'b1, 1'b1, 1'b0);
        c0 = clr_cnt; s0 = se_cnt; d0 = done_cnt;
        send_frame(16'h0013, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8) tick(1'b1);
        check_val("p5_shifts", se_cnt - s0, 8);
        check_val("p5_data", int'(sr_q), 'h13);
        check_val("p5_done", done_cnt - d0, 1);
        check_val("p5_perr", int'(u_if.parity_err), 0);

        // same, wrong parity bit 0
        d0 = done_cnt;
        send_frame(16'h0013, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) tick(1'b1);
        check_val("p5bad_data", int'(sr_q), 'h13);
        check_val("p5bad_done", done_cnt - d0, 1);
        check_val("p5bad_perr", int'(u_if.parity_err), 1);
        check_val("p5bad_ferr", int'(u_if.frame_err), 0);

        // start glitch: low for 4 ticks only
        config_set(4'd8, 1'b0, 1'b1, 1'b0);
        c0 = clr_cnt; d0 = done_cnt;
        repeat (4) tick(1'b0);
        check_val("glitch_busy_mid", int'(u_if.busy), 1);
        repeat (12) tick(1'b1);
        check_val("glitch_clr", clr_cnt - c0, 0);
        check_val("glitch_done", done_cnt - d0, 0);
        check_val("glitch_busy_end", int'(u_if.busy), 0);

        // 8N2 with a low second stop bit
        config_set(4'd8, 1'b0, 1'b1, 1'b1);
        c0 = clr_cnt; d0 = done_cnt;
        send_frame(16'h005A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (40) tick(1'b0);
        check_val("n2_done", done_cnt - d0, 1);
        check_val("n2_data", int'(sr_q), 'h5A);
        check_val("n2_ferr", int'(u_if.frame_err), 1);
        check_val("n2_berr", int'(u_if.break_err), 0);
        check_val("n2_wait_busy", int'(u_if.busy), 1);
        check_val("n2_no_restart", clr_cnt - c0, 1);
        tick(1'b1);
        tick(1'b1);
        check_val("n2_idle_busy", int'(u_if.busy), 0);
        repeat (6) tick(1'b1);

        // break: line low for 30 bit times, parity enabled
        config_set(4'd8, 1'b1, 1'b1, 1'b0);
        c0 = clr_cnt; d0 = done_cnt;
        repeat (30) send_bit(1'b0);
        check_val("brk_done", done_cnt - d0, 1);
        check_val("brk_berr", int'(u_if.break_err), 1);
        check_val("brk_ferr", int'(u_if.frame_err), 1);
        check_val("brk_perr", int'(u_if.parity_err), 0);
        check_val("brk_busy_low", int'(u_if.busy), 1);
        repeat (20) tick(1'b1);
        check_val("brk_busy_high", int'(u_if.busy), 0);
        check_val("brk_single_start", clr_cnt - c0, 1);

        // srst during the 4th data bit
        config_set(4'd8, 1'b0, 1'b1, 1'b0);
        s0 = se_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (8) tick(1'b1);
        check_val("rst_mid_shifts", se_cnt - s0, 3);
        check_val("rst_mid_busy", int'(u_if.busy), 1);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check_val("rst_mid_outputs", outs(), 0);
        repeat (20) tick(1'b1);
        c0 = clr_cnt; s0 = se_cnt; d0 = done_cnt;
        send_frame(16'h003C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) tick(1'b1);
        check_val("post_rst_data", int'(sr_q), 'h3C);
        check_val("post_rst_shifts", se_cnt - s0, 8);
        check_val("post_rst_done", done_cnt - d0, 1);
        check_val("post_rst_flags", int'({u_if.parity_err, u_if.frame_err, u_if.break_err}), 0);
        check_val("pulse_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/gh_uart_rx_sampler.md
Name: gh_uart_rx_sampler

Overview:
- UART receive bit-sampling controller, directly upstream of the serial-in/parallel-out shift-enable shift register in the UART receive path.
- Detects a start bit on the synchronized serial line and samples each bit at mid-cell using a 16x baud clock enable.
- Drives the shift register's clear, shift-enable and serial-data inputs so the received word ends right-aligned in a WIDTH-bit register.
- Reports completion, parity error, framing error and break per character.

Parameters:
- WIDTH, 8, maximum data bits and width of the downstream shift register; legal range 5..16.

Ports:
- clk  in  1  system clock
- srst  in  1  reset, synchronous, active-high
- brc  in  1  16x baud-rate clock enable, one clk cycle wide
- rx  in  1  serial input, already synchronized to clk
- num_bits  in  4  data bits per character; values below 5 are treated as 5, values above WIDTH as WIDTH
- parity_en  in  1  a parity bit follows the data bits
- parity_even  in  1  1 = even parity, 0 = odd parity
- two_stop  in  1  1 = two stop bits, 0 = one stop bit
- sr_clr  out  1  synchronous clear to the shift register
- sr_se  out  1  shift enable to the shift register
- sr_d  out  1  serial data to the shift register
- rx_done  out  1  one-cycle pulse when a character is complete
- parity_err  out  1  parity error for the last character
- frame_err  out  1  framing error for the last character
- break_err  out  1  break detected for the last character
- busy  out  1  high in every state except IDLE

Behaviour:
- Everything advances only on clk cycles where brc=1; a "tick" is one such cycle.
- All outputs are registered. srst at any time forces IDLE and drives every output low in the following cycle, including in the middle of a character.
- Configuration (num_bits clamped, parity_en, parity_even, two_stop) is latched when the start bit is confirmed and held for the rest of the character.
- States: IDLE, START, DATA, PAD, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: on a tick with rx=0, clear the tick counter and go to START.
- START: count ticks. At the 8th tick (mid-bit), if rx=1 it was a glitch: return to IDLE with no outputs. If rx=0, pulse sr_clr for one cycle, clear the running parity, and go to DATA.
- Sampling point: each subsequent bit is sampled every 16 ticks after the previous sample point, measured by a free-running 4-bit tick counter that wraps.
- DATA: at each sample, pulse sr_se with sr_d=rx for one cycle (LSB first) and XOR rx into the parity. After num_bits samples, go to PAD; if num_bits=WIDTH, skip PAD.
- PAD: on each of the next (WIDTH-num_bits) ticks, pulse sr_se with sr_d=0. The tick counter keeps running, so the next sample point is unaffected. This leaves the data right-aligned in the shift register with zero upper bits. Then go to PARITY if parity_en, else STOP1.
- PARITY: at the sample point, parity_err_next = (parity XOR rx) != (parity_even ? 0 : 1).
- STOP1: at the sample point, a stop bit of 0 flags a framing error. Then go to STOP2 if two_stop, otherwise complete the character.
- STOP2: at the sample point, a stop bit of 0 flags a framing error; then complete the character.
- Completion: in the cycle after the final stop sample:
  - rx_done=1 for exactly one cycle;
  - parity_err, frame_err and break_err update together and hold until the next rx_done or srst.
- Break: break_err=1 when all data bits, the parity bit (if enabled) and every stop bit sampled 0. frame_err is also 1 in that case.
- After completion: go to WAIT_HIGH if frame_err_next, else IDLE. WAIT_HIGH returns to IDLE on the first tick with rx=1, so a held-low line never retriggers.
- sr_clr, sr_se and rx_done are never asserted in the same cycle.
- In IDLE: sr_se=0, sr_d=0, sr_clr=0.

Test Plan:
- 8N1 frame, byte 0xA5, WIDTH=8, 16 ticks per bit -> one sr_clr, then 8 sr_se pulses with sr_d=1,0,1,0,0,1,0,1; one rx_done; all error flags 0; shift register holds 0xA5.
- num_bits=5, data 0x13, even parity, parity bit 1 -> 5 data shifts then 3 shifts with sr_d=0; shift register 0x13; parity_err=0. Repeat with parity bit 0 -> parity_err=1.
- rx low for only 4 ticks in IDLE -> back to IDLE at the 8th tick; no sr_clr, no rx_done, busy returns to 0.
- 8N2 frame with second stop bit 0 -> frame_err=1, break_err=0, state WAIT_HIGH until rx=1.
- rx held low for 30 bit times, parity enabled -> one rx_done with break_err=1 and frame_err=1; no second start until rx goes high and then low again.
- srst asserted during the 4th data bit -> next cycle all outputs 0 and busy=0; a following clean 0x3C frame is received correctly.
